// File: rtl/axi4_lite_single_master.sv
// Single-outstanding AXI4-Lite initiator.
// Converts a command/response handshake into one complete AXI4-Lite write or read.
// All AXI and response outputs are registered. cmd_ready is decoded from the state.
// DATA_BIT_WIDTH must be 32 or 64.
module axi4_lite_single_master #(
    parameter int ADDR_BIT_WIDTH = 32,
    parameter int DATA_BIT_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          sync_rst,

    // command handshake
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_is_write,
    input  logic [ADDR_BIT_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_BIT_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_BIT_WIDTH/8-1:0]   cmd_wstrb,

    // response handshake
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_is_write,
    output logic [DATA_BIT_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                    rsp_resp,

    // write address channel
    output logic [ADDR_BIT_WIDTH-1:0]     awaddr,
    output logic [2:0]                    awprot,
    output logic                          awvalid,
    input  logic                          awready,

    // write data channel
    output logic [DATA_BIT_WIDTH-1:0]     wdata,
    output logic [DATA_BIT_WIDTH/8-1:0]   wstrb,
    output logic                          wvalid,
    input  logic                          wready,

    // write response channel
    input  logic [1:0]                    bresp,
    input  logic                          bvalid,
    output logic                          bready,

    // read address channel
    output logic [ADDR_BIT_WIDTH-1:0]     araddr,
    output logic [2:0]                    arprot,
    output logic                          arvalid,
    input  logic                          arready,

    // read data channel
    input  logic [DATA_BIT_WIDTH-1:0]     rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rvalid,
    output logic                          rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    state_t state;

    // A write request channel is finished when it already handshook or handshakes now.
    logic aw_done;
    logic w_done;

    // Decode the request-channel completion flags.
    assign aw_done = !awvalid || awready;
    assign w_done  = !wvalid  || wready;

    // NOTE: cmd_ready is a pure decode of the registered state.
    // It never depends on cmd_valid, so the upstream handshake has no combinational loop.
    assign cmd_ready = (state == IDLE);

    // Only unprivileged, secure data accesses are issued.
    assign awprot = 3'b000;
    assign arprot = 3'b000;

    // Transaction FSM together with every registered AXI and response output.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            // NOTE: sequential state uses non-blocking assignments.
            // All registers then update together from the values before the edge.
            state        <= IDLE;
            rsp_valid    <= 1'b0;
            rsp_is_write <= 1'b0;
            rsp_rdata    <= '0;
            rsp_resp     <= 2'b00;
            awvalid      <= 1'b0;
            wvalid       <= 1'b0;
            bready       <= 1'b0;
            arvalid      <= 1'b0;
            rready       <= 1'b0;
            awaddr       <= '0;
            wdata        <= '0;
            wstrb        <= '0;
            araddr       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_is_write) begin
                            awaddr  <= cmd_addr;
                            wdata   <= cmd_wdata;
                            wstrb   <= cmd_wstrb;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR_REQ;
                        end else begin
                            araddr  <= cmd_addr;
                            arvalid <= 1'b1;
                            state   <= RD_REQ;
                        end
                    end
                end

                WR_REQ: begin
                    // AW and W retire independently; the request ends once both are done.
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (bvalid) begin
                        bready       <= 1'b0;
                        rsp_is_write <= 1'b1;
                        rsp_rdata    <= '0;
                        rsp_resp     <= bresp;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end

                RD_REQ: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_RESP;
                    end
                end

                RD_RESP: begin
                    if (rvalid) begin
                        rready       <= 1'b0;
                        rsp_is_write <= 1'b0;
                        rsp_rdata    <= rdata;
                        rsp_resp     <= rresp;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end

                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_single_master.sv
// Self-checking bench for axi4_lite_single_master.
// A configurable AXI4-Lite slave model drives the DUT.
// Expected responses are queued as each command is driven and compared as each response is taken.
// A per-cycle trace of the DUT valid/ready outputs supports the timing checks.
module tb_axi4_lite_single_master;

    typedef struct packed {
        logic        is_write;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;

    localparam int TR_AWV  = 0;
    localparam int TR_WV   = 1;
    localparam int TR_BR   = 2;
    localparam int TR_ARV  = 3;
    localparam int TR_RR   = 4;
    localparam int TR_RSPV = 5;
    localparam int TR_LEN  = 4096;

    logic        clk;
    logic        sync_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_is_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_is_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    rsp_t sb[$];

    // slave model configuration
    int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
    logic [1:0]  slv_bresp, slv_rresp;
    logic [31:0] slv_rdata;

    // per-cycle trace, index = number of rising edges seen so far
    logic [5:0]  tr        [0:TR_LEN-1];
    logic [31:0] tr_araddr [0:TR_LEN-1];

    axi4_lite_single_master #(
        .ADDR_BIT_WIDTH(32),
        .DATA_BIT_WIDTH(32)
    ) dut (
        .clk(clk), .sync_rst(sync_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_write(cmd_is_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_write(rsp_is_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Record the DUT outputs once per cycle, on the falling edge.
    initial forever begin
        @(negedge clk);
        if (cyc < TR_LEN) begin
            tr[cyc]        = {rsp_valid, rready, arvalid, bready, wvalid, awvalid};
            tr_araddr[cyc] = araddr;
        end
    end

    // Slave model: decides its ready/valid outputs on the falling edge for the next rising edge.
    initial begin : slave
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        bit aw_got, w_got, r_pend;
        bit aw_fire, w_fire, ar_fire, b_fire, r_fire;
        awready = 0; wready = 0; arready = 0; bvalid = 0; bresp = 0;
        rvalid = 0; rdata = 0; rresp = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; r_pend = 0;
        aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
        forever begin
            @(negedge clk);
            if (sync_rst) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; bresp = 0;
                rvalid = 0; rdata = 0; rresp = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; r_pend = 0;
            end else begin
                if (aw_fire) aw_got = 1;
                if (w_fire)  w_got  = 1;
                if (ar_fire) r_pend = 1;
                if (b_fire)  bvalid = 0;
                if (r_fire)  rvalid = 0;

                if (awvalid) begin
                    if (aw_cnt >= aw_wait) awready = 1;
                    else begin awready = 0; aw_cnt++; end
                end else begin awready = 0; aw_cnt = 0; end

                if (wvalid) begin
                    if (w_cnt >= w_wait) wready = 1;
                    else begin wready = 0; w_cnt++; end
                end else begin wready = 0; w_cnt = 0; end

                if (arvalid) begin
                    if (ar_cnt >= ar_wait) arready = 1;
                    else begin arready = 0; ar_cnt++; end
                end else begin arready = 0; ar_cnt = 0; end

                if (aw_got && w_got && !bvalid) begin
                    if (b_cnt >= b_wait) begin
                        bvalid = 1; bresp = slv_bresp; aw_got = 0; w_got = 0; b_cnt = 0;
                    end else b_cnt++;
                end

                if (r_pend && !rvalid) begin
                    if (r_cnt >= r_wait) begin
                        rvalid = 1; rdata = slv_rdata; rresp = slv_rresp; r_pend = 0; r_cnt = 0;
                    end else r_cnt++;
                end
            end
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            ar_fire = arvalid && arready;
            b_fire  = bvalid && bready;
            r_fire  = rvalid && rready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t want finish before 200000", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic int run_len(int b, int from);
        int n = 0;
        while (from + n < TR_LEN && tr[from + n][b] === 1'b1) n++;
        return n;
    endfunction

    function automatic int first_hi(int b, int from);
        for (int k = 0; k < 64 && from + k < TR_LEN; k++) begin
            if (tr[from + k][b] === 1'b1) return k;
        end
        return -1;
    endfunction

    function automatic string fmt(rsp_t r);
        return $sformatf("w=%0b rdata=%h resp=%b", r.is_write, r.rdata, r.resp);
    endfunction

    task automatic set_slave(input int aw, input int w, input int ar, input int b, input int r);
        aw_wait = aw; w_wait = w; ar_wait = ar; b_wait = b; r_wait = r;
    endtask

    // Present a command and queue the response the slave configuration implies.
    task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        rsp_t e;
        cmd_is_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        e.is_write = w;
        e.rdata    = w ? 32'h0 : slv_rdata;
        e.resp     = w ? slv_bresp : slv_rresp;
        sb.push_back(e);
    endtask

    // Wait for the command to be accepted; t is the accepting edge.
    task automatic wait_accept(output int t);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, want 1", cmd_ready, n);
            cmd_valid = 1'b0; t = cyc;
            return;
        end
        @(posedge clk); #1;
        t = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Wait for the response handshake; t is the handshake edge.
    task automatic wait_rsp(output rsp_t obs, output int t);
        int n = 0;
        while (!(rsp_valid === 1'b1 && rsp_ready === 1'b1) && n < 100) begin
            @(negedge clk); n++;
        end
        if (n >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, want 1", rsp_valid, n);
            obs = 'x; t = cyc;
            return;
        end
        obs = {rsp_is_write, rsp_rdata, rsp_resp};
        t = cyc + 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        sync_rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_is_write, rsp_rdata, rsp_resp, awvalid, wvalid, bready, arvalid,
             rready, awaddr, wdata, wstrb, araddr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rsp_v=%b awv=%b wv=%b br=%b arv=%b rr=%b awaddr=%h wdata=%h araddr=%h, want all 0",
                     rsp_valid, awvalid, wvalid, bready, arvalid, rready, awaddr, wdata, araddr);
        end
        n_checks++;
        if ({awprot, arprot} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_prot: got awprot=%b arprot=%b, want 000 000", awprot, arprot);
        end
        sync_rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cmd_ready: got %b, want 1", cmd_ready);
        end
    endtask

    task automatic test_write_zero_wait();
        rsp_t obs, exp;
        int t, th;
        set_slave(0, 0, 0, 0, 0); slv_bresp = 2'b00; rsp_ready = 1'b1;
        drive_cmd(1'b1, 32'h0, 32'h0000_00F0, 4'hF);
        wait_accept(t);
        wait_rsp(obs, th);
        n_checks++;
        if (run_len(TR_AWV, t) !== 1 || run_len(TR_WV, t) !== 1) begin
            n_fail++;
            $display("FAIL wr_valid_len: got awvalid=%0d wvalid=%0d cycles, want 1 1",
                     run_len(TR_AWV, t), run_len(TR_WV, t));
        end
        n_checks++;
        if (awaddr !== 32'h0 || wdata !== 32'h0000_00F0 || wstrb !== 4'hF) begin
            n_fail++;
            $display("FAIL wr_payload: got awaddr=%h wdata=%h wstrb=%h, want 0 000000f0 f",
                     awaddr, wdata, wstrb);
        end
        n_checks++;
        if (first_hi(TR_RSPV, t) !== 2) begin
            n_fail++;
            $display("FAIL wr_latency: got rsp_valid %0d cycles after accept, want 2",
                     first_hi(TR_RSPV, t));
        end
        exp = sb.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL wr_rsp: got %s, want %s", fmt(obs), fmt(exp));
        end
    endtask

    task automatic test_read();
        rsp_t obs, exp;
        int t, th, n;
        set_slave(0, 0, 2, 0, 0); slv_rdata = 32'h1234_5678; slv_rresp = 2'b00; rsp_ready = 1'b1;
        drive_cmd(1'b0, 32'h4, 32'h0, 4'h0);
        wait_accept(t);
        wait_rsp(obs, th);
        n_checks++;
        if (run_len(TR_ARV, t) !== 3) begin
            n_fail++;
            $display("FAIL rd_arvalid_len: got %0d cycles, want 3", run_len(TR_ARV, t));
        end
        n = 0;
        for (int k = 0; k < 3; k++) if (tr_araddr[t + k] === 32'h4) n++;
        n_checks++;
        if (n !== 3) begin
            n_fail++;
            $display("FAIL rd_araddr_stable: got %0d cycles at 0x4, want 3", n);
        end
        n_checks++;
        if (first_hi(TR_RSPV, t) !== 4) begin
            n_fail++;
            $display("FAIL rd_latency: got rsp_valid %0d cycles after accept, want 4",
                     first_hi(TR_RSPV, t));
        end
        exp = sb.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL rd_rsp: got %s, want %s", fmt(obs), fmt(exp));
        end
    endtask

    task automatic test_skewed_aw_w();
        rsp_t obs, exp;
        int t, th;
        set_slave(0, 3, 0, 0, 0); slv_bresp = 2'b00; rsp_ready = 1'b1;
        drive_cmd(1'b1, 32'h10, 32'hCAFE_0001, 4'h5);
        wait_accept(t);
        wait_rsp(obs, th);
        n_checks++;
        if (run_len(TR_AWV, t) !== 1) begin
            n_fail++;
            $display("FAIL skew_awvalid_len: got %0d cycles, want 1", run_len(TR_AWV, t));
        end
        n_checks++;
        if (run_len(TR_WV, t) !== 4) begin
            n_fail++;
            $display("FAIL skew_wvalid_len: got %0d cycles, want 4", run_len(TR_WV, t));
        end
        n_checks++;
        if (first_hi(TR_BR, t) !== 4) begin
            n_fail++;
            $display("FAIL skew_bready_rise: got %0d cycles after accept, want 4",
                     first_hi(TR_BR, t));
        end
        exp = sb.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL skew_rsp: got %s, want %s", fmt(obs), fmt(exp));
        end
    endtask

    task automatic test_error_passthrough();
        rsp_t obs, exp;
        int t, th;
        set_slave(0, 0, 0, 1, 2); slv_bresp = 2'b10; slv_rresp = 2'b11;
        slv_rdata = 32'hDEAD_BEEF; rsp_ready = 1'b1;
        drive_cmd(1'b1, 32'h20, 32'h0000_1111, 4'hF);
        wait_accept(t);
        wait_rsp(obs, th);
        n_checks++;
        if (first_hi(TR_RSPV, t) !== 3) begin
            n_fail++;
            $display("FAIL err_wr_latency: got %0d, want 3", first_hi(TR_RSPV, t));
        end
        exp = sb.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL err_wr_rsp: got %s, want %s", fmt(obs), fmt(exp));
        end
        drive_cmd(1'b0, 32'h24, 32'h0, 4'h0);
        wait_accept(t);
        wait_rsp(obs, th);
        n_checks++;
        if (first_hi(TR_RSPV, t) !== 4) begin
            n_fail++;
            $display("FAIL err_rd_latency: got %0d, want 4", first_hi(TR_RSPV, t));
        end
        exp = sb.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL err_rd_rsp: got %s, want %s", fmt(obs), fmt(exp));
        end
    endtask

    task automatic test_rsp_backpressure();
        rsp_t snap, obs, exp;
        int t, th, t2, n, bad;
        set_slave(0, 0, 0, 0, 0); slv_bresp = 2'b00; rsp_ready = 1'b0;
        drive_cmd(1'b1, 32'h8, 32'hA5A5_A5A5, 4'h3);
        wait_accept(t);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        n_checks++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_rsp_valid: got %b, want 1", rsp_valid);
        end
        snap = {rsp_is_write, rsp_rdata, rsp_resp};
        slv_rdata = 32'h5555_AAAA; slv_rresp = 2'b00;
        drive_cmd(1'b0, 32'hC, 32'h0, 4'h0);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || {rsp_is_write, rsp_rdata, rsp_resp} !== snap ||
                cmd_ready !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d unstable cycles, want 0", bad);
        end
        exp = sb.pop_front();
        n_checks++;
        if (snap !== exp) begin
            n_fail++;
            $display("FAIL bp_wr_rsp: got %s, want %s", fmt(snap), fmt(exp));
        end
        rsp_ready = 1'b1;
        th = cyc + 1;
        wait_accept(t2);
        n_checks++;
        if (t2 - th !== 1) begin
            n_fail++;
            $display("FAIL bp_next_accept: got %0d cycles after rsp handshake, want 1", t2 - th);
        end
        wait_rsp(obs, th);
        exp = sb.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL bp_rd_rsp: got %s, want %s", fmt(obs), fmt(exp));
        end
    endtask

    task automatic test_reset_mid_write();
        rsp_t obs, exp;
        int t, th;
        set_slave(5, 5, 0, 0, 0); slv_bresp = 2'b00; rsp_ready = 1'b1;
        drive_cmd(1'b1, 32'h30, 32'h7777_7777, 4'hF);
        wait_accept(t);
        n_checks++;
        if (awvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_awvalid: got %b before reset, want 1", awvalid);
        end
        void'(sb.pop_back());
        sync_rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({rsp_valid, rsp_is_write, rsp_rdata, rsp_resp, awvalid, wvalid, bready, arvalid,
             rready, awaddr, wdata, wstrb, araddr} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got awv=%b wv=%b awaddr=%h wdata=%h wstrb=%h rsp_v=%b, want all 0",
                     awvalid, wvalid, awaddr, wdata, wstrb, rsp_valid);
        end
        @(negedge clk);
        @(negedge clk);
        sync_rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_cmd_ready: got %b, want 1", cmd_ready);
        end
        set_slave(0, 0, 0, 0, 0); slv_rdata = 32'hCAFE_F00D; slv_rresp = 2'b00;
        drive_cmd(1'b0, 32'h34, 32'h0, 4'h0);
        wait_accept(t);
        wait_rsp(obs, th);
        exp = sb.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL rstmid_rd_rsp: got %s, want %s", fmt(obs), fmt(exp));
        end
    endtask

    task automatic test_back_to_back();
        rsp_t obs, exp;
        int t0, t1, t2, th;
        set_slave(0, 0, 0, 0, 0); slv_bresp = 2'b00; slv_rresp = 2'b00;
        slv_rdata = 32'h0BAD_CAFE; rsp_ready = 1'b1;
        drive_cmd(1'b1, 32'h40, 32'h0101_0101, 4'hF);
        wait_accept(t0);
        drive_cmd(1'b0, 32'h44, 32'h0, 4'h0);
        wait_rsp(obs, th);
        exp = sb.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_rsp0: got %s, want %s", fmt(obs), fmt(exp));
        end
        wait_accept(t1);
        n_checks++;
        if (t1 - t0 !== 4) begin
            n_fail++;
            $display("FAIL b2b_period0: got %0d cycles between accepts, want 4", t1 - t0);
        end
        drive_cmd(1'b1, 32'h48, 32'h0202_0202, 4'h1);
        wait_rsp(obs, th);
        exp = sb.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_rsp1: got %s, want %s", fmt(obs), fmt(exp));
        end
        wait_accept(t2);
        n_checks++;
        if (t2 - t1 !== 4) begin
            n_fail++;
            $display("FAIL b2b_period1: got %0d cycles between accepts, want 4", t2 - t1);
        end
        wait_rsp(obs, th);
        exp = sb.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_rsp2: got %s, want %s", fmt(obs), fmt(exp));
        end
    endtask

    initial begin
        sync_rst = 1'b1; cmd_valid = 1'b0; cmd_is_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        set_slave(0, 0, 0, 0, 0); slv_bresp = 2'b00; slv_rresp = 2'b00; slv_rdata = '0;
        @(negedge clk);
        test_reset();
        test_write_zero_wait();
        test_read();
        test_skewed_aw_w();
        test_error_passthrough();
        test_rsp_backpressure();
        test_reset_mid_write();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_lite_single_master.md
# axi4_lite_single_master

Single-outstanding AXI4-Lite initiator that turns a simple command/response handshake into complete AXI4-Lite write or read transactions. It drives the register-bank slaves in the verification environment, such as the reduction-register DUT, from synthesizable stimulus logic. It can also serve as a minimal CPU-less bus driver in FPGA test designs. It holds exactly one transaction in flight and fully honours AXI4-Lite valid/ready rules on all five channels.

## Interface
- ADDR_BIT_WIDTH, 32, AXI4-Lite address width
- DATA_BIT_WIDTH, 32, AXI4-Lite data width; must be 32 or 64
- clk  input  1  clock; all logic on rising edge
- sync_rst  input  1  synchronous, active-high reset
- cmd_valid / cmd_ready  input / output  1 / 1  command handshake
- cmd_is_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_BIT_WIDTH  byte address
- cmd_wdata  input  DATA_BIT_WIDTH  write data; ignored for reads
- cmd_wstrb  input  DATA_BIT_WIDTH/8  write strobes; ignored for reads
- rsp_valid / rsp_ready  output / input  1 / 1  response handshake
- rsp_is_write  output  1  echo of the command type
- rsp_rdata  output  DATA_BIT_WIDTH  read data; 0 for writes
- rsp_resp  output  2  BRESP or RRESP, passed through unchanged
- awaddr, awprot(3), awvalid / awready  out, out, out / in  write address channel
- wdata, wstrb, wvalid / wready  out, out, out / in  write data channel
- bresp(2), bvalid / bready  in, in / out  write response channel
- araddr, arprot(3), arvalid / arready  out, out, out / in  read address channel
- rdata, rresp(2), rvalid / rready  in, in, in / out  read data channel

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- **IDLE**
  - cmd_ready=1; all AXI valid/ready outputs are 0.
  - On cmd_valid & cmd_ready, capture addr, wdata, wstrb and type into registers.
  - Go to WR_REQ (write) or RD_REQ (read).
- **WR_REQ**
  - awvalid and wvalid are asserted together.
  - Each one drops independently in the cycle after its own handshake (awvalid&awready, wvalid&wready).
  - Handshakes may occur in the same cycle or in any order.
  - Once both have completed, go to WR_RESP.
- **WR_RESP**
  - bready=1.
  - On bvalid, capture bresp, set rsp_rdata=0, go to RSP.
- **RD_REQ**
  - arvalid=1.
  - On arready, go to RD_RESP.
- **RD_RESP**
  - rready=1.
  - On rvalid, capture rdata/rresp, go to RSP.
- **RSP**
  - rsp_valid=1; response fields stay stable.
  - On rsp_ready, go to IDLE.
- Protocol rules:
  - awprot and arprot are constant 3'b000.
  - Address and data outputs stay stable while their valid is high.
  - A valid output never depends combinationally on its ready input.
- All AXI and response outputs are registered; cmd_ready is decoded directly from state==IDLE.
- SLVERR and DECERR are not treated as errors internally; they are only forwarded on rsp_resp.

## Timing
- Reset: state=IDLE. All of the following reset to 0:
  - rsp_valid, rsp_is_write, rsp_rdata, rsp_resp;
  - awvalid, wvalid, bready, arvalid, rready;
  - awaddr, wdata, wstrb, araddr.
- cmd_ready=1 in the first cycle after reset deasserts.
- Command accepted at edge T: awvalid/wvalid (or arvalid) are high from T+1.
- Zero-wait-state slave gives a minimum latency of 3 edges from command accept to rsp_valid:
  - AW/W (or AR) handshake at T+1;
  - bready/rready high from T+2, B/R handshake at T+2;
  - rsp_valid high from T+3.
- Back-to-back commands: cmd_ready rises the cycle after the rsp handshake.
  - Peak throughput is 1 transaction per 4 cycles.
- Any extra slave wait states add one cycle each to the latency.
- bvalid/rvalid asserted before bready/rready are held by the slave per AXI rules, then accepted normally.
- sync_rst mid-transaction:
  - On the next edge all outputs return to their reset values and the FSM returns to IDLE.
  - The in-flight transaction is abandoned; the slave is reset by the same reset.

## Test plan
- **Write, zero wait:** cmd write addr 0x0, data 0x0000_00F0, wstrb 0xF; all readies high.
  - Required: awvalid/wvalid high for exactly 1 cycle with awaddr=0x0, wdata=0x0000_00F0.
  - Required: rsp_valid at T+3 with rsp_is_write=1, rsp_resp=2'b00.
- **Read:** cmd read addr 0x4 with slave rdata=0x1234_5678, arready delayed 2 cycles.
  - Required: arvalid stays high 3 cycles with araddr stable.
  - Required: rsp_rdata=0x1234_5678, rsp_is_write=0.
- **Skewed AW/W:** awready at T+1, wready at T+4.
  - Required: awvalid drops at T+2 while wvalid stays high until T+5.
  - Required: bready rises only at T+5.
- **Error passthrough:** slave returns bresp=2'b10 on a write, then rresp=2'b11 on a read.
  - Required: rsp_resp is 2'b10, then 2'b11.
- **Response backpressure:** rsp_ready held low for 5 cycles.
  - Required: rsp_valid and all rsp fields stay stable; cmd_ready stays 0.
  - Required: the next command is accepted 1 cycle after the rsp handshake.
- **Reset mid-write:** assert sync_rst while in WR_REQ (awvalid=1).
  - Required: at the next edge all outputs are 0 and cmd_ready=1 after release.
  - Required: a following read completes correctly.
